median_window_ctrl: RTL and testbench

Raster-scan sequencer for the 9-input pipelined median sorter in the salt-and-pepper noise filter. It accepts a grayscale pixel stream with valid/ready and buffers two image lines. It forms 3x3 windows, drives the sorter one window per cycle, and tracks window validity through the sorter's fixed latency. It also absorbs downstream backpressure in an output FIFO, using a credit scheme, because the sorter cannot stall.

---
 rtl/median_window_ctrl_if.sv | 27 ++
 rtl/median_window_ctrl.sv | 170 +++++++++++++++++
 tb/tb_median_window_ctrl.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/median_window_ctrl_if.sv
// Pixel stream, sorter and control signals of the median window sequencer.
interface median_window_ctrl_if;
    logic        start;
    logic        busy;
    logic        frame_done;
    logic [7:0]  in_px;
    logic        in_valid;
    logic        in_ready;
    logic [71:0] win_px;
    logic [7:0]  med_in;
    logic [7:0]  out_px;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;

    // Environment side: pixel source, sorter and downstream sink.
    modport master (
        output start, in_px, in_valid, med_in, out_ready,
        input  busy, frame_done, in_ready, win_px, out_px, out_valid, out_last
    );

    // Controller side.
    modport slave (
        input  start, in_px, in_valid, med_in, out_ready,
        output busy, frame_done, in_ready, win_px, out_px, out_valid, out_last
    );
endinterface

// File: rtl/median_window_ctrl.sv
// Raster-scan 3x3 window sequencer for a fixed-latency pipelined median sorter.
// Two line buffers form the window; a valid pipe tracks windows through the
// sorter; an output FIFO with credit-gated input absorbs downstream stalls.
module median_window_ctrl #(
    parameter int IMG_W      = 640,
    parameter int IMG_H      = 480,
    parameter int MED_LAT    = 10,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    median_window_ctrl_if.slave bus
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int OW = $clog2(FIFO_DEPTH + MED_LAT + 2) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t              state;
    logic                busy_r;
    logic                done_r;
    logic [CW-1:0]       col;
    logic [RW-1:0]       row;
    logic [7:0]          line0 [IMG_W];
    logic [7:0]          line1 [IMG_W];
    logic [8:0][7:0]     win;
    // Bit 0 is the window-valid stage (window on win_px); bit MED_LAT means
    // the matching median is on med_in this cycle.
    logic [MED_LAT:0]    vld_pipe;
    logic [MED_LAT:0]    lst_pipe;
    logic [7:0]          fifo_px [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] fifo_lst;
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;
    logic [PW:0]         cnt;
    logic [PW:0]         cnt_nxt;
    logic [OW-1:0]       outstanding;

    logic last_col, last_row, issue_here, in_ready, accept, push, pop, drain_empty;

    assign last_col   = (col == CW'(IMG_W - 1));
    assign last_row   = (row == RW'(IMG_H - 1));
    assign issue_here = (row >= RW'(2)) && (col >= CW'(2));
    assign push       = vld_pipe[MED_LAT];
    assign pop        = (cnt != '0) && bus.out_ready;
    assign cnt_nxt    = cnt + (PW+1)'(push) - (PW+1)'(pop);
    // In DRAIN nothing new enters, so the pipe is empty after this edge iff
    // its lower bits are clear now.
    assign drain_empty = (vld_pipe[MED_LAT-1:0] == '0) && (cnt_nxt == '0);

    // Credits: every window in flight or queued owns a FIFO slot.
    always_comb begin
        outstanding = OW'(cnt);
        for (int i = 0; i <= MED_LAT; i++)
            outstanding = outstanding + OW'(vld_pipe[i]);
    end

    assign in_ready = (state == RUN) &&
                      ((outstanding + OW'(issue_here)) <= OW'(FIFO_DEPTH - 1));
    assign accept   = bus.in_valid && in_ready;

    // Frame sequencing FSM with raster counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            col    <= '0;
            row    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        state  <= RUN;
                        busy_r <= 1'b1;
                        col    <= '0;
                        row    <= '0;
                    end
                end
                RUN: begin
                    if (accept) begin
                        if (last_col) begin
                            col <= '0;
                            if (last_row) state <= DRAIN;
                            else          row   <= row + RW'(1);
                        end else begin
                            col <= col + CW'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (drain_empty) begin
                        state  <= DONE;
                        done_r <= 1'b1;
                        busy_r <= 1'b0;
                    end
                end
                DONE: begin
                    done_r <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Line buffers and window shift on each accepted pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < IMG_W; i++) begin
                line0[i] <= '0;
                line1[i] <= '0;
            end
            win <= '0;
        end else if (accept) begin
            line0[col] <= line1[col];
            line1[col] <= bus.in_px;
            win[0] <= win[1];
            win[1] <= win[2];
            win[2] <= line0[col];
            win[3] <= win[4];
            win[4] <= win[5];
            win[5] <= line1[col];
            win[6] <= win[7];
            win[7] <= win[8];
            win[8] <= bus.in_px;
        end
    end

    // Window validity and last-flag tracking through the sorter latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            lst_pipe <= '0;
        end else begin
            vld_pipe <= {vld_pipe[MED_LAT-1:0], accept && issue_here};
            lst_pipe <= {lst_pipe[MED_LAT-1:0], accept && last_col && last_row};
        end
    end

    // Output FIFO, first-word fall-through.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_px[i] <= '0;
            fifo_lst <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt      <= '0;
        end else begin
            if (push) begin
                fifo_px[wr_ptr]  <= bus.med_in;
                fifo_lst[wr_ptr] <= lst_pipe[MED_LAT];
                wr_ptr           <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            cnt <= cnt_nxt;
        end
    end

    assign bus.busy       = busy_r;
    assign bus.frame_done = done_r;
    assign bus.in_ready   = in_ready;
    assign bus.win_px     = win;
    assign bus.out_valid  = (cnt != '0);
    assign bus.out_px     = (cnt != '0) ? fifo_px[rd_ptr] : 8'd0;
    assign bus.out_last   = (cnt != '0) ? fifo_lst[rd_ptr] : 1'b0;
endmodule

// File: tb/tb_median_window_ctrl.sv
// Directed bench: a 5x4 and an 8x8 controller, each driving a behavioural
// fixed-latency median sorter.
module tb_median_window_ctrl;
    localparam int LAT   = 10;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       sel = 1'b0;
    logic       start_s = 1'b0;
    logic       in_valid_s = 1'b0;
    logic [7:0] in_px_s = 8'd0;
    logic       out_ready_s = 1'b1;
    int         or_mode = 0;

    median_window_ctrl_if if5();
    median_window_ctrl_if if8();

    logic [7:0] sp5 [LAT];
    logic [7:0] sp8 [LAT];

    assign if5.start     = start_s && !sel;
    assign if5.in_px     = in_px_s;
    assign if5.in_valid  = in_valid_s && !sel;
    assign if5.out_ready = out_ready_s;
    assign if5.med_in    = sp5[LAT-1];
    assign if8.start     = start_s && sel;
    assign if8.in_px     = in_px_s;
    assign if8.in_valid  = in_valid_s && sel;
    assign if8.out_ready = out_ready_s;
    assign if8.med_in    = sp8[LAT-1];

    median_window_ctrl #(.IMG_W(5), .IMG_H(4), .MED_LAT(LAT), .FIFO_DEPTH(DEPTH))
        u_dut5 (.clk(clk), .rst(rst), .bus(if5.slave));
    median_window_ctrl #(.IMG_W(8), .IMG_H(8), .MED_LAT(LAT), .FIFO_DEPTH(DEPTH))
        u_dut8 (.clk(clk), .rst(rst), .bus(if8.slave));

    logic        busy_m, fd_m, in_ready_m, out_valid_m, out_last_m;
    logic [7:0]  out_px_m;
    logic [71:0] win_px_m;
    assign busy_m      = sel ? if8.busy       : if5.busy;
    assign fd_m        = sel ? if8.frame_done : if5.frame_done;
    assign in_ready_m  = sel ? if8.in_ready   : if5.in_ready;
    assign out_valid_m = sel ? if8.out_valid  : if5.out_valid;
    assign out_last_m  = sel ? if8.out_last   : if5.out_last;
    assign out_px_m    = sel ? if8.out_px     : if5.out_px;
    assign win_px_m    = sel ? if8.win_px     : if5.win_px;

    function automatic logic [7:0] med9(logic [71:0] w);
        logic [7:0] a [9];
        logic [7:0] t;
        for (int k = 0; k < 9; k++) a[k] = w[8*k +: 8];
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8 - i; j++)
                if (a[j] > a[j+1]) begin t = a[j]; a[j] = a[j+1]; a[j+1] = t; end
        return a[4];
    endfunction

    // Sorter models: median of the presented window, LAT edges later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) begin sp5[i] <= '0; sp8[i] <= '0; end
        end else begin
            sp5[0] <= med9(if5.win_px);
            sp8[0] <= med9(if8.win_px);
            for (int i = 1; i < LAT; i++) begin sp5[i] <= sp5[i-1]; sp8[i] <= sp8[i-1]; end
        end
    end

    // Downstream ready pattern.
    always @(posedge clk) begin
        #1;
        case (or_mode)
            1:       out_ready_s = 1'($urandom_range(1));
            2:       out_ready_s = 1'b0;
            default: out_ready_s = 1'b1;
        endcase
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] got_px [$];
    bit         got_lst [$];
    int pop_cnt = 0, fd_cnt = 0, fd_cyc = 0, lp_cyc = 0, max_out = 0;
    int win_cyc = 0, ov_cyc = 0, fid = 0, mon_fid = 0, iss_cnt = 0;
    bit win_seen = 0, ov_seen = 0;
    logic [71:0] exp_win;

    // Output monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (fid != mon_fid) begin mon_fid = fid; win_seen = 0; ov_seen = 0; max_out = 0; end
        if (iss_cnt - pop_cnt > max_out) max_out = iss_cnt - pop_cnt;
        if (!win_seen && win_px_m == exp_win) begin win_seen = 1; win_cyc = cyc; end
        if (!ov_seen && out_valid_m) begin ov_seen = 1; ov_cyc = cyc; end
        if (fd_m) begin fd_cnt++; fd_cyc = cyc; end
        if (out_valid_m && out_ready_s) begin
            got_px.push_back(out_px_m);
            got_lst.push_back(out_last_m);
            pop_cnt++;
            if (out_last_m) lp_cyc = cyc;
        end
    end

    int n_chk = 0, n_fail = 0;
    int px_base = 0, fd_base = 0;

    task automatic chk(string tag, logic [71:0] got, logic [71:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pix(int mode, int x, int y);
        if (mode == 0) return 8'(x + 10*y);
        if (x == 2 && y == 1) return 8'd255;
        if (x == 3 && y == 2) return 8'd0;
        return 8'd50;
    endfunction

    task automatic send(int w, int h, int mode, bit rnd, int npx);
        int n = 0;
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                if (n < npx) begin
                    bit acc = 0;
                    int t = 0;
                    if (rnd)
                        while ($urandom_range(1) == 0) begin
                            in_valid_s = 1'b0; @(posedge clk); #1;
                        end
                    in_px_s = pix(mode, x, y);
                    in_valid_s = 1'b1;
                    while (!acc && t < 500) begin
                        @(negedge clk); acc = in_ready_m;
                        @(posedge clk); #1; t++;
                    end
                    if (!acc) chk($sformatf("in_ready_timeout_%0d_%0d", x, y), 0, 1);
                    if (x >= 2 && y >= 2) iss_cnt++;
                    n++;
                end
            end
        end
        in_valid_s = 1'b0;
    endtask

    task automatic begin_frame(bit s);
        sel = s; fid++; iss_cnt = pop_cnt;
        px_base = got_px.size(); fd_base = fd_cnt;
        start_s = 1'b1; @(posedge clk); #1; start_s = 1'b0;
        chk("busy_after_start", busy_m, 1);
    endtask

    task automatic run_frame(bit s, int w, int h, int mode, bit rnd, int hold, int spurious);
        int t = 0;
        begin_frame(s);
        or_mode = rnd ? 1 : (hold > 0 ? 2 : 0);
        fork
            send(w, h, mode, rnd, w*h);
            begin
                if (hold > 0) begin repeat (hold) @(posedge clk); #1; or_mode = rnd ? 1 : 0; end
            end
            begin
                for (int i = 0; i < spurious; i++) begin
                    repeat (7) @(posedge clk); #2; start_s = 1'b1;
                    @(posedge clk); #2; start_s = 1'b0;
                end
            end
        join
        while (fd_cnt == fd_base && t < 3000) begin @(posedge clk); t++; end
        if (fd_cnt == fd_base) chk("frame_done_timeout", 0, 1);
        repeat (3) @(posedge clk); #1;
        or_mode = 0;
    endtask

    task automatic check_frame(string nm, int w, int h, int mode);
        int k = 0;
        int last = (w-2)*(h-2) - 1;
        chk({nm, "_count"}, got_px.size() - px_base, (w-2)*(h-2));
        for (int cy = 1; cy <= h-2; cy++)
            for (int cx = 1; cx <= w-2; cx++) begin
                if (px_base + k < got_px.size()) begin
                    chk($sformatf("%s_px%0d", nm, k), got_px[px_base+k],
                        (mode == 0) ? 8'(cx + 10*cy) : 8'd50);
                    chk($sformatf("%s_last%0d", nm, k), got_lst[px_base+k], k == last);
                end
                k++;
            end
        chk({nm, "_fd_count"}, fd_cnt - fd_base, 1);
        chk({nm, "_fd_timing"}, fd_cyc, lp_cyc + 1);
        chk({nm, "_busy_idle"}, busy_m, 0);
    endtask

    initial begin
        for (int k = 0; k < 9; k++) exp_win[8*k +: 8] = 8'((k % 3) + 10*(k / 3));
        #12;
        chk("rst_busy", busy_m, 0);
        chk("rst_fd", fd_m, 0);
        chk("rst_in_ready", in_ready_m, 0);
        chk("rst_win", win_px_m, 0);
        chk("rst_out_valid", out_valid_m, 0);
        chk("rst_out_px", out_px_m, 0);
        chk("rst_out_last", out_last_m, 0);
        @(posedge clk); #1; rst = 1'b0;
        repeat (2) @(posedge clk); #1;
        chk("idle_in_ready", in_ready_m, 0);

        // 5x4 ramp, continuous flow, plus latency from the (2,2) window.
        run_frame(0, 5, 4, 0, 0, 0, 0);
        check_frame("ramp", 5, 4, 0);
        chk("win22_seen", win_seen, 1);
        chk("latency", ov_cyc - win_cyc, LAT + 1);

        // Impulse noise is removed.
        run_frame(0, 5, 4, 1, 0, 0, 0);
        check_frame("noise", 5, 4, 1);

        // 8x8 ramp with downstream stalled: credits cap outstanding work.
        run_frame(1, 8, 8, 0, 0, 60, 0);
        chk("max_outstanding", max_out, DEPTH - 1);
        check_frame("bp", 8, 8, 0);

        // Reset in the middle of a frame, then a clean frame with stray starts.
        begin_frame(0);
        send(5, 4, 0, 0, 13);
        rst = 1'b1; #1;
        chk("midrst_busy", busy_m, 0);
        chk("midrst_out_valid", out_valid_m, 0);
        chk("midrst_in_ready", in_ready_m, 0);
        @(posedge clk); @(posedge clk); #1; rst = 1'b0;
        @(posedge clk); #1;
        chk("midrst_pops", got_px.size() - px_base, 0);
        run_frame(0, 5, 4, 0, 0, 0, 2);
        check_frame("after_rst", 5, 4, 0);

        // Random valid/ready toggling.
        run_frame(0, 5, 4, 0, 1, 0, 0);
        check_frame("rand", 5, 4, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
